// File: rtl/draw_sprite_pkg.sv
// Shared VGA bus layout and helpers for the sprite draw stage and its neighbours.
package draw_sprite_pkg;

    localparam int CNT_W = 12;
    localparam int RGB_W = 12;

    typedef struct packed {
        logic [CNT_W-1:0] vcount;
        logic             vsync;
        logic             vblnk;
        logic [CNT_W-1:0] hcount;
        logic             hsync;
        logic             hblnk;
        logic [RGB_W-1:0] rgb;
    } vga_bus_t;

    localparam int VGA_BUS_SIZE = $bits(vga_bus_t);

    localparam logic [RGB_W-1:0] TRANSPARENT_DEFAULT = 12'hF0F;

    // Span test done at 13 bits so an origin near 4095 clips instead of wrapping.
    function automatic logic in_span(input logic [CNT_W-1:0] pos,
                                     input logic [CNT_W-1:0] origin,
                                     input int unsigned      size);
        logic [CNT_W:0] p;
        logic [CNT_W:0] o;
        p = {1'b0, pos};
        o = {1'b0, origin};
        return (p >= o) && (p < (o + (CNT_W+1)'(size)));
    endfunction

endpackage

// File: rtl/draw_sprite_if.sv
// Pixel stream, position/control and sprite ROM signals of the sprite draw stage.
interface draw_sprite_if
    import draw_sprite_pkg::*;
#(
    parameter int ADDR_W = 14
) ();
    vga_bus_t          vga_in;
    vga_bus_t          vga_out;
    logic [CNT_W-1:0]  xpos_in;
    logic [CNT_W-1:0]  ypos_in;
    logic              anim_en;
    logic              highlight;
    logic [ADDR_W-1:0] rom_addr;
    logic [RGB_W-1:0]  rom_rgb;

    modport master (
        output vga_in, xpos_in, ypos_in, anim_en, highlight, rom_rgb,
        input  vga_out, rom_addr
    );

    modport slave (
        input  vga_in, xpos_in, ypos_in, anim_en, highlight, rom_rgb,
        output vga_out, rom_addr
    );
endinterface

// File: rtl/draw_sprite_delay_line.sv
// Generic synchronous-reset register shift line; reusable by any draw stage.
module vga_delay_line #(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] line_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
        end else begin
            line_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
        end
    end

    assign q_o = line_q[DEPTH-1];
endmodule

// File: rtl/draw_sprite.sv
// Animated sprite overlay: frame-latched position, ROM fetch, colour-key and highlight.
module draw_sprite
    import draw_sprite_pkg::*;
#(
    parameter int               WIDTH        = 48,
    parameter int               HEIGHT       = 64,
    parameter int               ADDR_X_BITS  = 6,
    parameter int               ADDR_Y_BITS  = 6,
    parameter int               FRAMES       = 4,
    parameter int               FRAME_BITS   = 2,
    parameter int               FRAME_PERIOD = 8,
    parameter int               ROM_LATENCY  = 1,
    parameter logic [RGB_W-1:0] TRANSPARENT  = TRANSPARENT_DEFAULT,
    parameter logic [RGB_W-1:0] HILITE_COLOR = 12'h00F
) (
    input  logic        pclk,
    input  logic        rst,
    draw_sprite_if.slave bus
);
    localparam int AW   = FRAME_BITS + ADDR_Y_BITS + ADDR_X_BITS;
    localparam int VS_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam int DL_W = VGA_BUS_SIZE + 2;

    vga_bus_t              vin;
    logic                  vs_prev_q;
    logic                  vs_rise;
    logic [CNT_W-1:0]      x_q, x_d, y_q, y_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [VS_W-1:0]       vs_cnt_q, vs_cnt_d;
    logic [AW-1:0]         rom_addr_q, rom_addr_d;
    logic                  inside_s0;
    logic [ADDR_X_BITS-1:0] dx;
    logic [ADDR_Y_BITS-1:0] dy;
    logic [DL_W-1:0]       dl_out;
    vga_bus_t              vd;
    logic                  inside_dl, hl_dl;
    vga_bus_t              out_q, out_d;

    assign vin     = bus.vga_in;
    assign vs_rise = vin.vsync & ~vs_prev_q;

    // Position and animation only move on a vsync rising edge, so a frame never tears.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        frame_d  = frame_q;
        vs_cnt_d = vs_cnt_q;
        if (vs_rise) begin
            x_d = bus.xpos_in;
            y_d = bus.ypos_in;
            if (bus.anim_en) begin
                if (vs_cnt_q == VS_W'(FRAME_PERIOD - 1)) begin
                    vs_cnt_d = '0;
                    frame_d  = (frame_q == FRAME_BITS'(FRAMES - 1)) ? '0 : frame_q + 1'b1;
                end else begin
                    vs_cnt_d = vs_cnt_q + 1'b1;
                end
            end
        end
    end

    assign inside_s0 = in_span(vin.hcount, x_q, WIDTH) && in_span(vin.vcount, y_q, HEIGHT)
                       && !vin.hblnk && !vin.vblnk;
    assign dx         = vin.hcount[ADDR_X_BITS-1:0] - x_q[ADDR_X_BITS-1:0];
    assign dy         = vin.vcount[ADDR_Y_BITS-1:0] - y_q[ADDR_Y_BITS-1:0];
    assign rom_addr_d = {frame_q, dy, dx};

    vga_delay_line #(
        .DEPTH (ROM_LATENCY + 1),
        .W     (DL_W)
    ) u_delay (
        .clk (pclk),
        .rst (rst),
        .d_i ({vin, inside_s0, bus.highlight}),
        .q_o (dl_out)
    );

    assign {vd, inside_dl, hl_dl} = dl_out;

    always_comb begin
        out_d = vd;
        if (inside_dl && hl_dl)                      out_d.rgb = HILITE_COLOR;
        else if (inside_dl && bus.rom_rgb != TRANSPARENT) out_d.rgb = bus.rom_rgb;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            vs_prev_q  <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            frame_q    <= '0;
            vs_cnt_q   <= '0;
            rom_addr_q <= '0;
            out_q      <= '0;
        end else begin
            vs_prev_q  <= vin.vsync;
            x_q        <= x_d;
            y_q        <= y_d;
            frame_q    <= frame_d;
            vs_cnt_q   <= vs_cnt_d;
            rom_addr_q <= rom_addr_d;
            out_q      <= out_d;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.vga_out  = out_q;
endmodule

// File: tb/tb_draw_sprite.sv
// Directed bench for draw_sprite, run side by side with ROM latency 1 and 3.
module tb_draw_sprite;
    import draw_sprite_pkg::*;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    always #5 pclk = ~pclk;

    vga_bus_t    vin;
    logic [11:0] xpos, ypos;
    logic        anim_en, hl;
    logic        rom_mode;
    logic [11:0] rom_const;
    logic [11:0] rom1_q [1];
    logic [11:0] rom3_q [3];

    draw_sprite_if #(.ADDR_W(14)) if1 ();
    draw_sprite_if #(.ADDR_W(14)) if3 ();

    assign if1.vga_in = vin;  assign if3.vga_in = vin;
    assign if1.xpos_in = xpos; assign if3.xpos_in = xpos;
    assign if1.ypos_in = ypos; assign if3.ypos_in = ypos;
    assign if1.anim_en = anim_en; assign if3.anim_en = anim_en;
    assign if1.highlight = hl; assign if3.highlight = hl;
    assign if1.rom_rgb = rom1_q[0];
    assign if3.rom_rgb = rom3_q[2];

    draw_sprite #(.FRAME_PERIOD(2), .ROM_LATENCY(1)) u1 (.pclk(pclk), .rst(rst), .bus(if1));
    draw_sprite #(.FRAME_PERIOD(2), .ROM_LATENCY(3)) u3 (.pclk(pclk), .rst(rst), .bus(if3));

    function automatic logic [11:0] rom_fn(input logic [13:0] a);
        return rom_mode ? (a[11:0] ^ 12'h3C3) : rom_const;
    endfunction

    // Synchronous ROM models: data appears ROM_LATENCY edges after the address.
    always @(posedge pclk) begin
        rom1_q[0] <= rom_fn(if1.rom_addr);
        rom3_q[0] <= rom_fn(if3.rom_addr);
        rom3_q[1] <= rom3_q[0];
        rom3_q[2] <= rom3_q[1];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply_vec(input logic [11:0] h, input logic [11:0] v, input logic hb,
                             input logic vb, input logic [11:0] rgb, input logic hlv,
                             input logic [11:0] rc, input logic [11:0] exp, input string nm);
        vin.hcount = h; vin.vcount = v; vin.hblnk = hb; vin.vblnk = vb;
        vin.hsync = 1'b0; vin.vsync = 1'b0; vin.rgb = rgb;
        hl = hlv; rom_const = rc;
        repeat (6) @(posedge pclk);
        @(negedge pclk);
        chk({nm, "_L1"}, 64'(if1.vga_out.rgb), 64'(exp));
        chk({nm, "_L3"}, 64'(if3.vga_out.rgb), 64'(exp));
    endtask

    task automatic vsync_pulse();
        @(negedge pclk); vin.vsync = 1'b1;
        repeat (2) @(negedge pclk);
        vin.vsync = 1'b0;
        repeat (2) @(negedge pclk);
    endtask

    task automatic check_frame(input logic [1:0] f, input string nm);
        apply_vec(12'd200, 12'd50, 1'b0, 1'b0, 12'hABC, 1'b0, 12'h123, 12'h123, nm);
        chk({nm, "_addr_L1"}, 64'(if1.rom_addr), 64'({f, 12'h000}));
        chk({nm, "_addr_L3"}, 64'(if3.rom_addr), 64'({f, 12'h000}));
    endtask

    // Reference behaviour for the streaming run: sprite at (100,50), frame 0, ROM = addr ^ 3C3.
    function automatic vga_bus_t model(input vga_bus_t i);
        int          dxi, dyi;
        logic [31:0] dxv, dyv;
        logic [11:0] rd;
        logic        ins;
        dxi = int'(i.hcount) - 100;
        dyi = int'(i.vcount) - 50;
        dxv = dxi; dyv = dyi;
        ins = (dxi >= 0) && (dxi < 48) && (dyi >= 0) && (dyi < 64) && !i.hblnk && !i.vblnk;
        rd  = {dyv[5:0], dxv[5:0]} ^ 12'h3C3;
        model = i;
        if (ins && rd != 12'hF0F) model.rgb = rd;
    endfunction

    typedef struct {
        logic [11:0] h, v;
        logic        hb, vb;
        logic [11:0] rgb;
        logic        hlv;
        logic [11:0] rc;
        logic [11:0] exp;
        string       nm;
    } vec_t;

    vec_t     tbl [14];
    vga_bus_t hist [70];

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{12'd100, 12'd50,  1'b0, 1'b0, 12'hABC, 1'b0, 12'h123, 12'h123, "hit_tl"};
        tbl[1]  = '{12'd147, 12'd113, 1'b0, 1'b0, 12'hABC, 1'b0, 12'h123, 12'h123, "hit_br"};
        tbl[2]  = '{12'd148, 12'd50,  1'b0, 1'b0, 12'hABC, 1'b0, 12'h123, 12'hABC, "right_out"};
        tbl[3]  = '{12'd100, 12'd114, 1'b0, 1'b0, 12'hABC, 1'b0, 12'h123, 12'hABC, "below_out"};
        tbl[4]  = '{12'd99,  12'd50,  1'b0, 1'b0, 12'hABC, 1'b0, 12'h123, 12'hABC, "left_out"};
        tbl[5]  = '{12'd100, 12'd49,  1'b0, 1'b0, 12'hABC, 1'b0, 12'h123, 12'hABC, "above_out"};
        tbl[6]  = '{12'd120, 12'd60,  1'b1, 1'b0, 12'hABC, 1'b0, 12'h123, 12'hABC, "hblnk"};
        tbl[7]  = '{12'd120, 12'd60,  1'b0, 1'b1, 12'hABC, 1'b0, 12'h123, 12'hABC, "vblnk"};
        tbl[8]  = '{12'd120, 12'd60,  1'b0, 1'b0, 12'hABC, 1'b0, 12'hF0F, 12'hABC, "transp"};
        tbl[9]  = '{12'd120, 12'd60,  1'b0, 1'b0, 12'hABC, 1'b1, 12'hF0F, 12'h00F, "hl_transp"};
        tbl[10] = '{12'd100, 12'd50,  1'b0, 1'b0, 12'hABC, 1'b1, 12'h123, 12'h00F, "hl_tl"};
        tbl[11] = '{12'd147, 12'd113, 1'b0, 1'b0, 12'hABC, 1'b1, 12'h123, 12'h00F, "hl_br"};
        tbl[12] = '{12'd148, 12'd113, 1'b0, 1'b0, 12'hABC, 1'b1, 12'h123, 12'hABC, "hl_right"};
        tbl[13] = '{12'd100, 12'd114, 1'b0, 1'b0, 12'hABC, 1'b1, 12'h123, 12'hABC, "hl_below"};

        // Reset with a live, in-box input stream
        vin = '{vcount: 12'd50, vsync: 1'b1, vblnk: 1'b0, hcount: 12'd100,
                hsync: 1'b1, hblnk: 1'b0, rgb: 12'hABC};
        xpos = 12'd100; ypos = 12'd50; anim_en = 1'b1; hl = 1'b1;
        rom_mode = 1'b0; rom_const = 12'h123;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            chk("rst_out_L1",  64'(if1.vga_out),  64'd0);
            chk("rst_out_L3",  64'(if3.vga_out),  64'd0);
            chk("rst_addr_L1", 64'(if1.rom_addr), 64'd0);
            chk("rst_addr_L3", 64'(if3.rom_addr), 64'd0);
        end
        vin.vsync = 1'b0; vin.hsync = 1'b0; anim_en = 1'b0; hl = 1'b0;
        rst = 1'b0;
        vsync_pulse();

        for (int i = 0; i < 14; i++)
            apply_vec(tbl[i].h, tbl[i].v, tbl[i].hb, tbl[i].vb, tbl[i].rgb,
                      tbl[i].hlv, tbl[i].rc, tbl[i].exp, tbl[i].nm);

        // Streaming run: every bus field must emerge exactly ROM_LATENCY+2 cycles later
        rom_mode = 1'b1; hl = 1'b0;
        for (int c = 0; c < 70; c++) begin
            logic [31:0] cv;
            cv = c;
            hist[c] = '{vcount: 12'd50 + 12'(cv[5:4]), vsync: cv[3], vblnk: 1'b0,
                        hcount: 12'd90 + 12'(c), hsync: cv[1], hblnk: (c % 7 == 3),
                        rgb: 12'h200 + 12'(c)};
        end
        for (int c = 0; c < 73; c++) begin
            @(negedge pclk);
            if (c >= 3 && c - 3 < 70) chk("stream_L1", 64'(if1.vga_out), 64'(model(hist[c-3])));
            if (c >= 5 && c - 5 < 70) chk("stream_L3", 64'(if3.vga_out), 64'(model(hist[c-5])));
            if (c < 70) vin = hist[c];
        end
        rom_mode = 1'b0;
        vin.vsync = 1'b0;

        // Position latch: mid-frame move has no effect until the next vsync edge
        xpos = 12'd200;
        apply_vec(12'd100, 12'd50, 1'b0, 1'b0, 12'hABC, 1'b0, 12'h123, 12'h123, "latch_old_in");
        apply_vec(12'd200, 12'd50, 1'b0, 1'b0, 12'hABC, 1'b0, 12'h123, 12'hABC, "latch_new_out");
        vsync_pulse();
        apply_vec(12'd100, 12'd50, 1'b0, 1'b0, 12'hABC, 1'b0, 12'h123, 12'hABC, "latch_old_out");
        apply_vec(12'd200, 12'd50, 1'b0, 1'b0, 12'hABC, 1'b0, 12'h123, 12'h123, "latch_new_in");

        // Animation with FRAME_PERIOD=2: 0,0,1,1,2,2,3,3,0
        anim_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            check_frame(2'((i / 2) % 4), "anim");
            vsync_pulse();
        end
        vsync_pulse();
        check_frame(2'd1, "anim_pre_freeze");
        anim_en = 1'b0;
        repeat (3) vsync_pulse();
        check_frame(2'd1, "anim_frozen");
        anim_en = 1'b1;
        vsync_pulse();
        check_frame(2'd1, "anim_resume1");
        vsync_pulse();
        check_frame(2'd2, "anim_resume2");
        anim_en = 1'b0;

        // Clipping near the right edge of the 12-bit space
        xpos = 12'd4080; ypos = 12'd50;
        vsync_pulse();
        apply_vec(12'd0,    12'd50,  1'b0, 1'b0, 12'hABC, 1'b0, 12'h123, 12'hABC, "clip_h0");
        apply_vec(12'd31,   12'd50,  1'b0, 1'b0, 12'hABC, 1'b0, 12'h123, 12'hABC, "clip_h31");
        apply_vec(12'd4090, 12'd50,  1'b0, 1'b0, 12'hABC, 1'b0, 12'h123, 12'h123, "clip_in");
        apply_vec(12'd4095, 12'd113, 1'b0, 1'b0, 12'hABC, 1'b0, 12'h123, 12'h123, "clip_corner");

        // Mid-frame reset: position and frame back to 0 until the next vsync edge
        @(negedge pclk); rst = 1'b1;
        @(negedge pclk); rst = 1'b0;
        apply_vec(12'd10, 12'd10, 1'b0, 1'b0, 12'hABC, 1'b0, 12'h123, 12'h123, "mrst_origin");
        chk("mrst_addr_L1", 64'(if1.rom_addr), 64'(14'h028A));
        chk("mrst_addr_L3", 64'(if3.rom_addr), 64'(14'h028A));
        apply_vec(12'd4090, 12'd50, 1'b0, 1'b0, 12'hABC, 1'b0, 12'h123, 12'hABC, "mrst_unlatched");
        vsync_pulse();
        apply_vec(12'd4090, 12'd50, 1'b0, 1'b0, 12'hABC, 1'b0, 12'h123, 12'h123, "mrst_relatched");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
